// File: rtl/timer_ctrl.sv
// Command-driven timer: START/STOP/RESUME/CLEAR control of a one-shot or periodic counter.
// Optional prescaler enabled by defining TIMER_CTRL_PRESCALE_EN (adds cmd_div port).
module timer_ctrl #(
    parameter int WIDTH = 8,
    parameter int PRE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_limit,
    input  logic             cmd_periodic,
`ifdef TIMER_CTRL_PRESCALE_EN
    input  logic [PRE_W-1:0] cmd_div,
`endif
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [7:0]       wrap_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    localparam logic [1:0] OP_START  = 2'b00;
    localparam logic [1:0] OP_STOP   = 2'b01;
    localparam logic [1:0] OP_RESUME = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    state_t           state;
    logic [WIDTH-1:0] limit_r;
    logic             periodic_r;
    logic             accept;
    logic             tick;

    assign accept = cmd_valid & cmd_ready;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

`ifdef TIMER_CTRL_PRESCALE_EN
    logic [PRE_W-1:0] div_r;
    logic [PRE_W-1:0] pre_cnt;

    assign tick = (pre_cnt == div_r);

    // Prescaler restarts on every START, RESUME or CLEAR so the first tick is a full period away.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (accept && cmd_op != OP_STOP) begin
            pre_cnt <= '0;
        end else if (state == RUN) begin
            pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (accept && cmd_op == OP_START) begin
            div_r <= cmd_div;
        end
    end
`else
    assign tick = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (accept && cmd_op == OP_START) begin
            limit_r    <= cmd_limit;
            periodic_r <= cmd_periodic;
        end
    end

    // Accepted commands take priority over a tick in the same cycle; that tick is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            wrap_cnt  <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b0;
        end else if (accept) begin
            cmd_ready <= 1'b0;
            done      <= 1'b0;
            case (cmd_op)
                OP_START: begin
                    state    <= RUN;
                    busy     <= 1'b1;
                    count    <= '0;
                    wrap_cnt <= '0;
                end
                OP_STOP: begin
                    if (state == RUN) begin
                        state <= PAUSE;
                    end
                end
                OP_RESUME: begin
                    if (state == PAUSE) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    count    <= '0;
                    wrap_cnt <= '0;
                end
            endcase
        end else begin
            cmd_ready <= 1'b1;
            done      <= 1'b0;
            if (state == RUN && tick) begin
                if (count == limit_r) begin
                    done <= 1'b1;
                    if (periodic_r) begin
                        count    <= '0;
                        wrap_cnt <= sat_inc8(wrap_cnt);
                    end else begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end
                end else begin
                    count <= count + WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: counter and limit width.
REQ-002 SHALL have parameter PRE_W, default 4: prescaler width; used only when TIMER_CTRL_PRESCALE_EN is defined.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port cmd_valid  input  1  command present.
REQ-006 SHALL have port cmd_ready  output  1  command can be accepted.
REQ-007 SHALL have port cmd_op  input  2  opcode: 00 START, 01 STOP, 10 RESUME, 11 CLEAR.
REQ-008 SHALL have port cmd_limit  input  WIDTH  terminal count, latched on START.
REQ-009 SHALL have port cmd_periodic  input  1  1 = periodic, 0 = one-shot; latched on START.
REQ-010 SHALL have port count  output  WIDTH  current count value.
REQ-011 SHALL have port busy  output  1  high in RUN or PAUSE.
REQ-012 SHALL have port done  output  1  one-cycle terminal pulse.
REQ-013 SHALL have port wrap_cnt  output  8  number of completed periods, saturating.

Function
REQ-014 SHALL implement four states: IDLE, RUN, PAUSE, DONE.
REQ-015 SHALL accept a command in any cycle where cmd_valid and cmd_ready are both 1.
REQ-016 SHALL drive cmd_ready from a register, and SHALL hold it low for exactly the one cycle after each accepted command; otherwise it is 1.
REQ-017 SHALL, on START accepted in any state: latch limit and mode, set count=0 and wrap_cnt=0, and go to RUN.
REQ-018 SHALL, on STOP in RUN: go to PAUSE with count held; on STOP in any other state: no effect.
REQ-019 SHALL, on RESUME in PAUSE: go to RUN with count unchanged; on RESUME in any other state: no effect.
REQ-020 SHALL, on CLEAR in any state: go to IDLE with count=0 and wrap_cnt=0.
REQ-021 SHALL, in RUN on each tick with count != limit: increment count by 1.
REQ-022 SHALL, in RUN on a tick with count == limit (terminal tick): register done=1 for exactly one cycle.
REQ-023 SHALL, on a terminal tick in one-shot mode: go to DONE with count held at limit.
REQ-024 SHALL, on a terminal tick in periodic mode: set count=0, stay in RUN, and increment wrap_cnt, saturating at 255.
REQ-025 SHALL treat limit=0 as a terminal tick on the first tick after START: periodic mode pulses done on every tick; one-shot mode goes to DONE after 1 tick.
REQ-026 SHALL, when a command is accepted in the same cycle as a tick, give the command priority: that tick is discarded and done is not pulsed.
REQ-027 SHALL hold count, done=0 and wrap_cnt in IDLE, PAUSE and DONE.
REQ-028 SHALL treat a tick as every clk cycle in RUN, unless modified by REQ-033.
REQ-029 SHALL generate all outputs from registers, with no combinational path from inputs to outputs.

Reset
REQ-030 SHALL, while rst=1, force: state=IDLE, count=0, wrap_cnt=0, done=0, busy=0, cmd_ready=0.
REQ-031 SHALL set cmd_ready=1 in the first cycle after rst is deasserted.
REQ-032 SHALL let rst asserted in any state, including mid-RUN, override every command and tick in that cycle.

Configuration
REQ-033 SHALL, with TIMER_CTRL_PRESCALE_EN defined: add port cmd_div (input, PRE_W bits), latched on START; a tick occurs every cmd_div+1 clk cycles in RUN; the prescaler clears on START, RESUME, CLEAR and reset.
REQ-034 SHALL, without TIMER_CTRL_PRESCALE_EN defined: have no cmd_div port and no prescaler logic; tick = every cycle in RUN.

Verification
REQ-035 SHALL cover one-shot: START, limit=3, periodic=0 -> count 0,1,2,3; done pulses once on the edge where count would pass 3; state DONE; count holds 3; busy=0.
REQ-036 SHALL cover periodic: START, limit=2, periodic=1, run 9 cycles -> count 0,1,2,0,1,2,...; done pulses 3 times; wrap_cnt=3.
REQ-037 SHALL cover pause: STOP at count=5 with limit=10, wait 4 cycles, RESUME -> count holds 5 for 5 cycles, then continues 6,7,...
REQ-038 SHALL cover collision: CLEAR accepted on the terminal-tick cycle -> done stays 0; count=0; state IDLE; cmd_ready=0 in the next cycle.
REQ-039 SHALL cover mid-run reset: rst=1 for 1 cycle mid-RUN with wrap_cnt=7 -> all outputs return to reset values; cmd_ready=1 the cycle after.
REQ-040 SHALL cover saturation (periodic, limit=0, 300 cycles): wrap_cnt=255 and holds there.
